agc_ctrl: RTL



---
 rtl/agc_pkg.sv | 50 +++++
 rtl/agc_step_calc.sv | 75 +++++++
 rtl/agc_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/agc_pkg.sv
// ============================================================================
// Module      : agc_pkg
// Description : Shared types and constants for the AGC loop controller.
//               Power values are unsigned Q3 dB (LSB = 0.125 dB).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package agc_pkg;

  // Loop controller states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_MEAS   = 3'd2,
    ST_UPDATE = 3'd3,
    ST_SETTLE = 3'd4
  } agc_state_e;

  // Signed error width: 9-bit unsigned power difference plus sign
  localparam int ERR_W   = 10;
  // Fractional bits of the dB scale used by target/hysteresis/estimate
  localparam int DB_FRAC = 3;
  // Widths of the dB-valued ports
  localparam int DB_W    = 9;
  localparam int HYST_W  = 5;
  // Threshold width: hysteresis doubled needs one extra bit
  localparam int THR_W   = HYST_W + 1;

  // Default parameter values
  localparam int DEF_GAIN_W    = 6;
  localparam int DEF_GAIN_INIT = 32;
  localparam int DEF_PERIOD    = 256;
  localparam int DEF_SETTLE    = 128;
  localparam int DEF_MAX_STEP  = 8;
  localparam int DEF_LOCK_CNT  = 4;
  localparam int DEF_TMO       = 16;

  // Largest of three integers, used to size the shared cycle counter
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/agc_step_calc.sv
// ============================================================================
// Module      : agc_step_calc
// Description : Combinational gain-step computation. Forms the signed power
//               error, its magnitude, the in-window decision against the
//               supplied threshold, and the saturated next gain code.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module agc_step_calc
  import agc_pkg::*;
#(
  parameter int GAIN_W   = DEF_GAIN_W,
  parameter int MAX_STEP = DEF_MAX_STEP
) (
  input  logic [DB_W-1:0]   pwr_i,
  input  logic [DB_W-1:0]   target_i,
  input  logic [THR_W-1:0]  thr_i,
  input  logic [GAIN_W-1:0] gain_i,
  output logic [GAIN_W-1:0] gain_o,
  output logic              changed_o,
  output logic              in_window_o
);

  // Arithmetic width wide enough for gain +/- step without wrap
  localparam int SW = ((GAIN_W > ERR_W) ? GAIN_W : ERR_W) + 1;

  logic signed [ERR_W-1:0] err;
  logic        [ERR_W-1:0] mag;
  logic        [ERR_W-1:0] step_raw;
  logic        [ERR_W-1:0] step;
  logic        [SW-1:0]    g_ext;
  logic        [SW-1:0]    s_ext;
  logic        [SW-1:0]    g_max;
  logic        [SW-1:0]    sum;
  logic        [SW-1:0]    next_ext;
  logic                    unused_hi;

  // Error, magnitude, clamped step and rail-saturated next gain
  always_comb begin
    err      = $signed({1'b0, pwr_i}) - $signed({1'b0, target_i});
    mag      = err[ERR_W-1] ? $unsigned(-err) : $unsigned(err);
    step_raw = mag >> 2;

    if (step_raw == '0) begin
      step = ERR_W'(1);
    end else if (step_raw > ERR_W'(MAX_STEP)) begin
      step = ERR_W'(MAX_STEP);
    end else begin
      step = step_raw;
    end

    g_ext    = SW'(gain_i);
    s_ext    = SW'(step);
    g_max    = SW'({GAIN_W{1'b1}});
    sum      = g_ext + s_ext;
    next_ext = g_ext;

    // Power too high lowers the gain, too low raises it
    if (err[ERR_W-1]) begin
      next_ext = (sum > g_max) ? g_max : sum;
    end else if (err != '0) begin
      next_ext = (g_ext >= s_ext) ? (g_ext - s_ext) : '0;
    end
  end

  assign in_window_o = (mag <= ERR_W'(thr_i));
  assign gain_o      = next_ext[GAIN_W-1:0];
  assign changed_o   = (gain_o != gain_i);
  // Upper bits are always zero after saturation to g_max
  assign unused_hi   = |next_ext[SW-1:GAIN_W];

endmodule

`default_nettype wire

// File: rtl/agc_ctrl.sv
// ============================================================================
// Module      : agc_ctrl
// Description : AGC loop controller. Periodically requests a power estimate,
//               compares it with the programmable target and steps a
//               saturating gain code, with a settling interval after each
//               change and a lock indication after repeated in-window results.
//               Optional build macro AGC_LOCK_FREEZE_EN widens the in-window
//               threshold to twice the hysteresis while locked.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module agc_ctrl
  import agc_pkg::*;
#(
  parameter int GAIN_W    = DEF_GAIN_W,
  parameter int GAIN_INIT = DEF_GAIN_INIT,
  parameter int PERIOD    = DEF_PERIOD,
  parameter int SETTLE    = DEF_SETTLE,
  parameter int MAX_STEP  = DEF_MAX_STEP,
  parameter int LOCK_CNT  = DEF_LOCK_CNT,
  parameter int TMO       = DEF_TMO
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              agc_en,
  input  logic [DB_W-1:0]   target_dB,
  input  logic [HYST_W-1:0] hyst_dB,
  input  logic [DB_W-1:0]   pwr_est_dB,
  input  logic              pwr_est_end,
  output logic              log_start,
  output logic [GAIN_W-1:0] gain_code,
  output logic              gain_upd,
  output logic              agc_lock,
  output logic              est_tmo
);

  // One counter is shared by WAIT, MEAS and SETTLE
  localparam int CNT_MAX = max3(PERIOD, SETTLE, TMO);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int LCK_W   = $clog2(LOCK_CNT + 1);

  agc_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [DB_W-1:0]    pwr_q, pwr_d;
  logic [GAIN_W-1:0]  gain_q, gain_d;
  logic               log_start_q, log_start_d;
  logic               gain_upd_q, gain_upd_d;
  logic               agc_lock_q, agc_lock_d;
  logic               est_tmo_q, est_tmo_d;

  logic [THR_W-1:0]   thr;
  logic [GAIN_W-1:0]  gain_next;
  logic               gain_changed;
  logic               in_window;

  // In-window threshold; optionally widened while locked to stop dithering
  always_comb begin
`ifdef AGC_LOCK_FREEZE_EN
    thr = agc_lock_q ? {hyst_dB, 1'b0} : {1'b0, hyst_dB};
`else
    thr = {1'b0, hyst_dB};
`endif
  end

  agc_step_calc #(
    .GAIN_W   (GAIN_W),
    .MAX_STEP (MAX_STEP)
  ) u_step (
    .pwr_i       (pwr_q),
    .target_i    (target_dB),
    .thr_i       (thr),
    .gain_i      (gain_q),
    .gain_o      (gain_next),
    .changed_o   (gain_changed),
    .in_window_o (in_window)
  );

  // Next-state, counter and output-register logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lock_cnt_d  = lock_cnt_q;
    pwr_d       = pwr_q;
    gain_d      = gain_q;
    log_start_d = 1'b0;
    gain_upd_d  = 1'b0;
    agc_lock_d  = agc_lock_q;
    est_tmo_d   = est_tmo_q;

    if (!agc_en) begin
      // Disable abandons any measurement in flight; gain is held
      state_d    = ST_IDLE;
      cnt_d      = '0;
      lock_cnt_d = '0;
      agc_lock_d = 1'b0;
      est_tmo_d  = 1'b0;
    end else begin
      // Lock follows the saturated lock counter by one cycle
      if (lock_cnt_q == LCK_W'(LOCK_CNT)) begin
        agc_lock_d = 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end

        ST_WAIT: begin
          if (cnt_q == CNT_W'(PERIOD - 1)) begin
            log_start_d = 1'b1;
            state_d     = ST_MEAS;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_MEAS: begin
          if (pwr_est_end) begin
            pwr_d   = pwr_est_dB;
            state_d = ST_UPDATE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(TMO - 1)) begin
            est_tmo_d = 1'b1;
            state_d   = ST_WAIT;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_UPDATE: begin
          cnt_d = '0;
          if (in_window) begin
            if (lock_cnt_q != LCK_W'(LOCK_CNT)) begin
              lock_cnt_d = lock_cnt_q + LCK_W'(1);
            end
            state_d = ST_WAIT;
          end else begin
            lock_cnt_d = '0;
            agc_lock_d = 1'b0;
            gain_d     = gain_next;
            if (gain_changed) begin
              gain_upd_d = 1'b1;
              state_d    = ST_SETTLE;
            end else begin
              // Already on a rail: skip settling
              state_d = ST_WAIT;
            end
          end
        end

        ST_SETTLE: begin
          if (cnt_q == CNT_W'(SETTLE - 1)) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      lock_cnt_q  <= '0;
      pwr_q       <= '0;
      gain_q      <= GAIN_W'(GAIN_INIT);
      log_start_q <= 1'b0;
      gain_upd_q  <= 1'b0;
      agc_lock_q  <= 1'b0;
      est_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      pwr_q       <= pwr_d;
      gain_q      <= gain_d;
      log_start_q <= log_start_d;
      gain_upd_q  <= gain_upd_d;
      agc_lock_q  <= agc_lock_d;
      est_tmo_q   <= est_tmo_d;
    end
  end

  assign log_start = log_start_q;
  assign gain_code = gain_q;
  assign gain_upd  = gain_upd_q;
  assign agc_lock  = agc_lock_q;
  assign est_tmo   = est_tmo_q;

endmodule

`default_nettype wire
